// File: rtl/needs_engine.sv
// Pet needs engine: six saturating need levels that rise on a prescaled game tick,
// are lowered by handshaked user actions, and freeze once the pet dies.

module needs_lane #(
    parameter int W      = 5,
    parameter int MAXV   = 15,
    parameter int PERIOD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  logic         dtick,
    input  logic         clr,
    input  logic [W-1:0] sub,
    input  logic [W-1:0] add,
    output logic [W-1:0] level
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic signed [W+1:0] MAXS = (W+2)'(MAXV);
    localparam logic [W-1:0] MAXL = W'(MAXV);

    logic [CW-1:0]         cnt;
    logic                  wrap;
    logic signed [W+1:0]   sum;
    logic [W-1:0]          post;
    logic [W-1:0]          nxt;

    assign wrap = adv && (cnt == CW'(PERIOD - 1));

    // Action first (clamped), then the tick's +1 or sleep -1 on the post-action value.
    always_comb begin
        sum = $signed({2'b00, level}) + $signed({2'b00, add}) - $signed({2'b00, sub});
        if (clr || sum[W+1])
            post = '0;
        else if (sum > MAXS)
            post = MAXL;
        else
            post = sum[W-1:0];
        nxt = post;
        if (dtick) begin
            if (post != '0) nxt = post - W'(1);
        end else if (wrap && post != MAXL) begin
            nxt = post + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            cnt   <= '0;
        end else begin
            level <= nxt;
            if (adv) cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end
endmodule

module needs_engine #(
    parameter int TICK_DIV       = 50000000,
    parameter int HUNGER_PERIOD  = 4,
    parameter int HAPPY_PERIOD   = 6,
    parameter int HYGIENE_PERIOD = 8,
    parameter int ENERGY_PERIOD  = 5,
    parameter int SOCIAL_PERIOD  = 7,
    parameter int HEALTH_PERIOD  = 3,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       action_valid,
    input  logic [2:0] action_code,
    output logic       action_ready,
    output logic [3:0] hunger,
    output logic [4:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic       sleeping,
    output logic       dead,
    output logic       bad_action,
    output logic       tick
);
    localparam int NN  = 6;
    localparam int LW  = 5;
    localparam int PW  = $clog2(TICK_DIV);
    localparam int CDW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    localparam int N_HUNGER = 0, N_HAPPY = 1, N_HEALTH = 2,
                   N_HYGIENE = 3, N_ENERGY = 4, N_SOCIAL = 5;
    localparam int PER  [NN] = '{HUNGER_PERIOD, HAPPY_PERIOD, HEALTH_PERIOD,
                                 HYGIENE_PERIOD, ENERGY_PERIOD, SOCIAL_PERIOD};
    localparam int MAXV [NN] = '{15, 31, 15, 15, 15, 15};

    localparam logic [2:0] A_FEED = 3'd0, A_PLAY = 3'd1, A_CLEAN = 3'd2,
                           A_MED  = 3'd3, A_SLEEP = 3'd4, A_PET = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_COOL, S_SLEEP, S_DEAD} state_t;

    state_t                 st;
    logic [PW-1:0]          pre;
    logic [CDW-1:0]         cd;
    logic                   slept;
    logic                   accept;
    logic                   sick;
    logic                   die;
    logic [NN-1:0][LW-1:0]  lvl;
    logic [NN-1:0][LW-1:0]  sub;
    logic [NN-1:0][LW-1:0]  add;
    logic [NN-1:0]          clr;
    logic [NN-1:0]          adv;
    logic [NN-1:0]          dtick;

    assign accept = action_valid && action_ready;
    assign tick   = (st != S_DEAD) && (pre == PW'(TICK_DIV - 1));
    assign sick   = (lvl[N_HUNGER] >= 5'd12) || (lvl[N_HYGIENE] >= 5'd12);
    assign die    = (lvl[N_HUNGER] == 5'd15) || (lvl[N_HEALTH] == 5'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre <= '0;
        else if (st != S_DEAD)
            pre <= tick ? '0 : pre + PW'(1);
    end

    always_comb begin
        sub   = '0;
        add   = '0;
        clr   = '0;
        dtick = '0;
        if (accept) begin
            case (action_code)
                A_FEED:  begin sub[N_HUNGER] = 5'd4; add[N_HYGIENE] = 5'd1; end
                A_PLAY:  begin sub[N_HAPPY] = 5'd6; sub[N_SOCIAL] = 5'd2; add[N_ENERGY] = 5'd2; end
                A_CLEAN: clr[N_HYGIENE] = 1'b1;
                A_MED:   begin sub[N_HEALTH] = 5'd6; add[N_HAPPY] = 5'd1; end
                A_PET:   begin sub[N_SOCIAL] = 5'd4; sub[N_HAPPY] = 5'd2; end
                default: ;
            endcase
        end
        // Health only ages while sick; sleep swaps energy decay for recovery.
        adv           = {NN{tick}};
        adv[N_HEALTH] = tick && sick;
        adv[N_ENERGY] = tick && (st != S_SLEEP);
        dtick[N_ENERGY] = tick && (st == S_SLEEP);
    end

    genvar i;
    for (i = 0; i < NN; i++) begin : g_lane
        needs_lane #(.W(LW), .MAXV(MAXV[i]), .PERIOD(PER[i])) u_lane (
            .clk   (clk),
            .reset (reset),
            .adv   (adv[i]),
            .dtick (dtick[i]),
            .clr   (clr[i]),
            .sub   (sub[i]),
            .add   (add[i]),
            .level (lvl[i])
        );
    end

    assign hunger    = 4'(lvl[N_HUNGER]);
    assign happiness = lvl[N_HAPPY];
    assign health    = 4'(lvl[N_HEALTH]);
    assign hygiene   = 4'(lvl[N_HYGIENE]);
    assign energy    = 4'(lvl[N_ENERGY]);
    assign social    = 4'(lvl[N_SOCIAL]);

    // Death overrides any transition; an action accepted that same edge still lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= S_IDLE;
            cd           <= '0;
            slept        <= 1'b0;
            action_ready <= 1'b0;
            sleeping     <= 1'b0;
            dead         <= 1'b0;
            bad_action   <= 1'b0;
        end else begin
            bad_action <= accept && (action_code[2:1] == 2'b11);
            if (die) begin
                st           <= S_DEAD;
                action_ready <= 1'b0;
                sleeping     <= 1'b0;
                dead         <= 1'b1;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (accept) begin
                            action_ready <= 1'b0;
                            if (action_code == A_SLEEP) begin
                                st       <= S_SLEEP;
                                sleeping <= 1'b1;
                                slept    <= 1'b0;
                            end else begin
                                st <= S_COOL;
                                cd <= '0;
                            end
                        end else begin
                            action_ready <= 1'b1;
                        end
                    end
                    S_COOL: begin
                        if (COOLDOWN_TICKS == 0 || (tick && cd == CDW'(COOLDOWN_TICKS - 1))) begin
                            st           <= S_IDLE;
                            action_ready <= 1'b1;
                        end else if (tick) begin
                            cd <= cd + CDW'(1);
                        end
                    end
                    S_SLEEP: begin
                        // Wake once energy sits at 0 after at least one sleeping tick.
                        if (lvl[N_ENERGY] == '0 && (slept || tick)) begin
                            st           <= S_IDLE;
                            sleeping     <= 1'b0;
                            action_ready <= 1'b1;
                        end else if (tick) begin
                            slept <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/needs_engine.md
Name: needs_engine

Overview:
- Produces the six need levels (hunger, happiness, health, hygiene, energy, social) consumed by the status/needs evaluation block.
- Higher value = worse. Needs rise over time on a prescaled tick; user actions arrive on a valid/ready handshake and lower them.
- Tracks sleep and death; a dead pet freezes all needs until reset.

Parameters:
- TICK_DIV, 50000000, clk cycles per game tick (min 2).
- HUNGER_PERIOD, 4, ticks per hunger +1.
- HAPPY_PERIOD, 6, ticks per happiness +1.
- HYGIENE_PERIOD, 8, ticks per hygiene +1.
- ENERGY_PERIOD, 5, ticks per energy +1 (awake only).
- SOCIAL_PERIOD, 7, ticks per social +1.
- HEALTH_PERIOD, 3, ticks per health +1 (sick only).
- COOLDOWN_TICKS, 2, ticks action_ready stays low after a non-sleep action.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- action_valid  input  1  action request.
- action_code  input  3  0 FEED, 1 PLAY, 2 CLEAN, 3 MEDICINE, 4 SLEEP, 5 PET, 6-7 reserved.
- action_ready  output  1  high only in IDLE.
- hunger  output  4  need level.
- happiness  output  5  need level.
- health  output  4  need level.
- hygiene  output  4  need level.
- energy  output  4  need level.
- social  output  4  need level.
- sleeping  output  1  high in SLEEP.
- dead  output  1  high in DEAD.
- bad_action  output  1  one-cycle pulse when a reserved code is accepted.
- tick  output  1  one-cycle pulse per game tick.

Behaviour:
- Reset (reset=0, async):
  - All need outputs 0. sleeping=0, dead=0, bad_action=0, tick=0.
  - Prescaler and per-need counters 0; FSM=IDLE.
  - action_ready=0 while reset is asserted, then 1.
- Prescaler:
  - Counts 0..TICK_DIV-1. tick=1 in the cycle count==TICK_DIV-1, then wraps to 0.
  - Runs in every state except DEAD.
- Decay, evaluated only on tick cycles:
  - Each need has its own counter. When the counter reaches PERIOD-1, the need gets +1 and the counter clears; otherwise the counter increments.
  - 4-bit needs saturate at 15; happiness saturates at 31.
  - Health counter advances only while sick (hunger>=12 or hygiene>=12). It holds otherwise.
  - Energy decays only while awake.
- Handshake and accept timing:
  - An action is accepted on the edge where action_valid && action_ready.
  - Need outputs show the action's effect after that same edge (1-cycle latency).
  - action_code is sampled only at accept.
- Action effects (subtractions saturate at 0, additions saturate at max):
  - FEED: hunger-4, hygiene+1.
  - PLAY: happiness-6, social-2, energy+2.
  - CLEAN: hygiene=0.
  - MEDICINE: health-6, happiness+1.
  - PET: social-4, happiness-2.
  - SLEEP: no level change; FSM->SLEEP.
  - 6/7: no change, bad_action pulse.
- Action coinciding with a tick: the action is applied first, then decay +1 is applied to the post-action value in the same edge.
- FSM states:
  - IDLE: ready=1. Accept non-sleep action -> COOLDOWN. Accept SLEEP -> SLEEP.
  - COOLDOWN: ready=0. Counts COOLDOWN_TICKS ticks, then -> IDLE. If COOLDOWN_TICKS=0, stays exactly 1 cycle.
  - SLEEP: ready=0, sleeping=1.
    - Each tick: energy-1 instead of the energy decay. Other needs decay normally.
    - Exit to IDLE on the edge after energy becomes 0. Entering with energy=0 exits on the first tick.
  - DEAD: entered from any state on the edge after hunger==15 or health==15.
    - dead=1, ready=0, tick stops, all levels frozen.
    - Leaves only via reset.
- Death priority: the death condition wins over any accept in the same cycle. The action is still applied on that edge, and death is re-evaluated on the next edge.
- Reset mid-cooldown or mid-sleep: immediate return to IDLE with all levels 0.

Test Plan:
- TICK_DIV=4, all periods default, no actions, run 16 ticks → tick every 4 cycles; hunger=4, happiness=2, hygiene=2, energy=3, social=2, health=0.
- Hunger=6 reached, FEED accepted outside a tick → hunger=2 and hygiene+1 next cycle; action_ready=0 for 2 ticks then 1. FEED held during cooldown is not accepted.
- Hunger=1, FEED → hunger=0 (saturation). Happiness=31 with decay tick → stays 31.
- Energy=3, SLEEP → sleeping=1; energy 2,1,0 on 3 successive ticks; then IDLE, ready=1, sleeping=0.
- Let hunger climb to 12 → health counter starts; hunger reaches 15 → dead=1 next cycle, tick stops, action_valid ignored, levels frozen; reset → all 0, ready=1.
- Action code 6 accepted → bad_action one-cycle pulse, no level change, COOLDOWN entered. FEED on a tick cycle with hunger=5 and hunger counter at PERIOD-1 → hunger=2.
